// File: rtl/spell_sram_arbiter_pkg.sv
// Shared definitions for the spell SRAM arbiter: FSM state encoding and watchdog defaults.
// Imported by the arbiter, its watchdog and the bus interface users.
package spell_sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbGrant0 = 2'd1,
    ArbGrant1 = 2'd2,
    ArbAbort  = 2'd3
  } arb_state_e;

  localparam int unsigned TimeoutCyclesDefault = 255;
  localparam int unsigned WdCountWidth         = 16;

  // Debug owner code: {granted, which requester}.
  localparam logic [1:0] OwnerNone = 2'b00;
  localparam logic [1:0] OwnerM0   = 2'b10;
  localparam logic [1:0] OwnerM1   = 2'b11;

endpackage

// File: rtl/spell_sram_arbiter_if.sv
// Wishbone signal bundle between two requesters, the arbiter and the OpenRAM port.
// slave = the arbiter's view; master = the surrounding requesters and memory.
interface spell_sram_arbiter_if;

  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic        sram_cyc_o;
  logic        sram_stb_o;
  logic        sram_we_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_adr_o;
  logic [31:0] sram_dat_o;
  logic [31:0] sram_dat_i;
  logic        sram_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
    input  sram_dat_i, sram_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  sram_cyc_o, sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o,
    output sram_dat_i, sram_ack_i
  );

endinterface

// File: rtl/spell_wb_watchdog.sv
// Wishbone transfer watchdog: counts stalled beats and flags when the limit is reached.
// Clear has priority over enable; the count holds when neither is asserted.
module spell_wb_watchdog
  import spell_sram_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TimeoutCyclesDefault,
  parameter int unsigned WIDTH = WdCountWidth
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] Threshold = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is a level on the current count; the owner decides whether ack overrides it.
  assign expired_o = (count_q == Threshold);

endmodule

// File: rtl/spell_sram_arbiter.sv
// Round-robin arbiter sharing the OpenRAM Wishbone port between the spell core (m0) and
// the host bridge (m1). The grant lasts a whole cyc; a watchdog aborts unacknowledged beats.
module spell_sram_arbiter
  import spell_sram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                 clock,
  input  logic                 reset_n,
  spell_sram_arbiter_if.slave  bus,
  output logic [1:0]           owner_o
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_owner_q;
  logic       last_owner_d;

  logic granted0;
  logic granted1;
  logic owner_cyc;
  logic owner_stb;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic timeout;

  assign granted0  = (state_q == ArbGrant0);
  assign granted1  = (state_q == ArbGrant1);
  assign owner_cyc = (granted0 & bus.m0_cyc_i) | (granted1 & bus.m1_cyc_i);
  assign owner_stb = (granted0 & bus.m0_stb_i) | (granted1 & bus.m1_stb_i);

  // Counter sits at zero outside a grant, so every grant starts from a clean count.
  assign wd_clear  = ~(granted0 | granted1) | bus.sram_ack_i;
  assign wd_enable = owner_stb & ~bus.sram_ack_i;

  // An ack in the threshold cycle wins, and a dropped cyc ends the cycle without error.
  assign timeout = owner_cyc & owner_stb & ~bus.sram_ack_i & wd_expired;

  spell_wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (WdCountWidth)
  ) u_watchdog (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ArbIdle;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ArbIdle: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          // Tie: the requester that did not own the bus last time wins.
          state_d      = last_owner_q ? ArbGrant0 : ArbGrant1;
          last_owner_d = ~last_owner_q;
        end else if (bus.m0_cyc_i) begin
          state_d      = ArbGrant0;
          last_owner_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d      = ArbGrant1;
          last_owner_d = 1'b1;
        end
      end
      ArbGrant0: begin
        if (!bus.m0_cyc_i) begin
          state_d = ArbIdle;
        end else if (timeout) begin
          state_d = ArbAbort;
        end
      end
      ArbGrant1: begin
        if (!bus.m1_cyc_i) begin
          state_d = ArbIdle;
        end else if (timeout) begin
          state_d = ArbAbort;
        end
      end
      ArbAbort: begin
        // last_owner still names the aborted requester; wait for it to release cyc.
        if (!(last_owner_q ? bus.m1_cyc_i : bus.m0_cyc_i)) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_comb begin
    bus.sram_cyc_o = 1'b0;
    bus.sram_stb_o = 1'b0;
    bus.sram_we_o  = 1'b0;
    bus.sram_sel_o = '0;
    bus.sram_adr_o = '0;
    bus.sram_dat_o = '0;
    bus.m0_ack_o   = 1'b0;
    bus.m0_err_o   = 1'b0;
    bus.m0_dat_o   = '0;
    bus.m1_ack_o   = 1'b0;
    bus.m1_err_o   = 1'b0;
    bus.m1_dat_o   = '0;
    owner_o        = OwnerNone;
    case (state_q)
      ArbGrant0: begin
        bus.sram_cyc_o = bus.m0_cyc_i;
        bus.sram_stb_o = bus.m0_stb_i;
        bus.sram_we_o  = bus.m0_we_i;
        bus.sram_sel_o = bus.m0_sel_i;
        bus.sram_adr_o = bus.m0_adr_i;
        bus.sram_dat_o = bus.m0_dat_i;
        bus.m0_ack_o   = bus.sram_ack_i;
        bus.m0_err_o   = timeout;
        bus.m0_dat_o   = bus.sram_dat_i;
        owner_o        = OwnerM0;
      end
      ArbGrant1: begin
        bus.sram_cyc_o = bus.m1_cyc_i;
        bus.sram_stb_o = bus.m1_stb_i;
        bus.sram_we_o  = bus.m1_we_i;
        bus.sram_sel_o = bus.m1_sel_i;
        bus.sram_adr_o = bus.m1_adr_i;
        bus.sram_dat_o = bus.m1_dat_i;
        bus.m1_ack_o   = bus.sram_ack_i;
        bus.m1_err_o   = timeout;
        bus.m1_dat_o   = bus.sram_dat_i;
        owner_o        = OwnerM1;
      end
      default: begin
        owner_o = OwnerNone;
      end
    endcase
  end

endmodule

// File: doc/spell_sram_arbiter.md
Name: spell_sram_arbiter

Overview:
- Shares the single OpenRAM Wishbone port between two requesters.
- Requester 0 is the spell core's memory unit; requester 1 is the host-side bridge used to load and inspect SRAM from the management CPU.
- Round-robin arbitration, with the grant held for a whole Wishbone cycle (cyc high).
- A per-transfer watchdog aborts slave transfers that never acknowledge, so the spell core cannot hang forever in its fetch or store states.

Parameters:
- TIMEOUT_CYCLES, 255, cycles a granted stb may wait for sram_ack_i before abort; legal range 1..65535.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  requester 0 Wishbone control.
- m0_sel_i  in  4  requester 0 byte select.
- m0_adr_i, m0_dat_i  in  32 each  requester 0 address and write data.
- m0_dat_o  out  32  read data to requester 0.
- m0_ack_o, m0_err_o  out  1 each  completion and timeout-abort to requester 0.
- m1_*  identical set for requester 1.
- sram_cyc_o, sram_stb_o, sram_we_o  out  1 each  to OpenRAM.
- sram_sel_o  out  4  to OpenRAM.
- sram_adr_o, sram_dat_o  out  32 each  to OpenRAM.
- sram_dat_i  in  32  read data from OpenRAM.
- sram_ack_i  in  1  acknowledge from OpenRAM.
- owner_o  out  2  debug: {granted, which}; fed to the logic analyzer.

Behaviour:
- States:
  - IDLE: no grant.
  - GRANT0 / GRANT1: requester owns the bus.
  - ABORT: timeout drain.
- Reset (reset_n low, asynchronous) forces:
  - state IDLE, last_owner 1 (so requester 0 wins the first tie), timeout counter 0.
  - All sram_* outputs 0; all m*_ack_o and m*_err_o 0; owner_o 0.
  - Reset asserted mid-transfer drops sram_cyc_o immediately, with no ack or err to anyone.
- IDLE → GRANTn on the next edge when mN_cyc_i is high.
  - Both requesting: grant the one that is not last_owner; update last_owner to the winner.
  - Grant latency is exactly 1 cycle from cyc high in IDLE to sram_cyc_o high.
- While in GRANTn, outputs are combinational from requester n:
  - sram_cyc_o = mN_cyc_i; sram_stb_o = mN_stb_i.
  - we, sel, adr and dat are passed through from requester n.
  - mN_ack_o = sram_ack_i; mN_dat_o = sram_dat_i.
  - The non-granted requester sees ack=0, err=0, dat_o=0.
  - When not in GRANTn, all sram_* outputs are 0.
- Grant held across multiple stb/ack beats for as long as mN_cyc_i stays high; no preemption.
- GRANTn → IDLE on the first edge where mN_cyc_i is low.
  - The IDLE cycle is a mandatory 1-cycle turnaround; back-to-back requests from both sides therefore alternate every beat plus 1 idle cycle.
- Watchdog:
  - A 16-bit counter clears on grant entry and on every cycle where sram_ack_i is high.
  - It increments each granted cycle with mN_stb_i high and sram_ack_i low.
  - When counter == TIMEOUT_CYCLES-1 and ack is still low:
    - mN_err_o pulses for exactly 1 cycle (combinational in that cycle).
    - Next state is ABORT.
  - The counter holds when stb is low.
- ABORT:
  - sram_* all 0 and ack/err 0 to both requesters.
  - Stays in ABORT while the aborted requester's cyc is high, then goes to IDLE.
  - A late sram_ack_i arriving during ABORT or IDLE is discarded.
- Simultaneous events:
  - sram_ack_i in the same cycle as the timeout threshold counts as success (ack wins, no err).
  - cyc dropping in the same cycle as the threshold goes to IDLE, no err.
- owner_o: 2'b00 in IDLE/ABORT, 2'b10 in GRANT0, 2'b11 in GRANT1.

Decomposition:
- Shared spell package/header:
  - State encoding localparams: ArbIdle, ArbGrant0, ArbGrant1, ArbAbort.
  - Default TIMEOUT_CYCLES constant.
- Sub-module spell_wb_watchdog (counter, clear/enable inputs, expired output) is natural and reusable for the host Wishbone slave.
- The mux logic stays flat in the arbiter.

Test Plan:
- Reset release, then m0 read (cyc+stb, adr 0x10) with the SRAM model acking 2 cycles after stb and returning 0xDEADBEEF → sram_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o on the model's ack; m0_dat_o = 0xDEADBEEF; m1 sees nothing.
- m0 and m1 assert cyc on the same edge straight after reset → m0 granted first (owner_o 2'b10). After m0 drops cyc: 1 idle cycle, then m1 granted (2'b11). Repeat both → m0 wins again (alternation).
- m1 holds cyc across 4 write beats (sel 4'b0011, data 1..4) while m0 requests → all 4 beats complete to m1 with no grant switch; m0 is granted only after m1 cyc low + 1 idle cycle.
- TIMEOUT_CYCLES=8, SRAM model never acks m0 → m0_err_o is high for exactly 1 cycle, 8 cycles after stb; sram_cyc_o low the cycle after. A late ack injected in ABORT is not seen by m0. m1 is granted only after m0 drops cyc.
- Ack arriving in the exact threshold cycle → ack delivered, err stays 0, bus remains GRANT0.
- reset_n pulled low asynchronously mid-transfer between edges → sram_cyc_o and owner_o go to 0 before the next clock edge. After release, state is IDLE and m0 wins a tie.
